// File: rtl/mc_controller.sv
// Multicycle MIPS-style control unit.
//
// A Moore FSM sequences each instruction through FETCH, DECODE and a
// class-specific tail, then returns to FETCH. Every control output is a
// combinational function of the current state. A few outputs also depend
// on op, funct or zero. While reset is high, every output is forced to 0.
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-high
//   op        in   [5:0] opcode from the instruction register
//   funct     in   [5:0] funct field from the instruction register
//   zero      in   ALU zero flag, used in BRANCH
//   pcen      out  PC register enable
//   irwrite   out  instruction register enable
//   regwrite  out  register file write enable
//   memwrite  out  memory write enable
//   iord      out  memory address select (0=PC, 1=ALUOut)
//   alusrca   out  ALU A select (0=PC, 1=A register)
//   alusrcb   out  [1:0] ALU B select (B, 4, ext imm, ext imm<<2)
//   pcsrc     out  [1:0] next-PC select (ALU, ALUOut, jump target)
//   regdst    out  write-register select (0=rt, 1=rd)
//   memtoreg  out  write-data select (0=ALUOut, 1=MDR)
//   alucont   out  [3:0] ALU operation
//   signext   out  immediate extension (1=sign, 0=zero)
//   shiftl16  out  shift extended immediate left by 16
//   state     out  [3:0] current FSM state (debug)
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic [3:0] alucont,
  output logic       signext,
  output logic       shiftl16,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXEC = 4'd6,
    RTWB   = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1000;
  localparam logic [3:0] ALU_XOR = 4'b1001;

  state_t cur_state;
  state_t nxt_state;

  // R-type ALU operation. An unrecognised funct falls back to ADD.
  function automatic logic [3:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: rtype_alu = ALU_ADD;
      6'b100010: rtype_alu = ALU_SUB;
      6'b100100: rtype_alu = ALU_AND;
      6'b100101: rtype_alu = ALU_OR;
      6'b100111: rtype_alu = ALU_NOR;
      6'b100110: rtype_alu = ALU_XOR;
      6'b101010: rtype_alu = ALU_SLT;
      default:   rtype_alu = ALU_ADD;
    endcase
  endfunction

  // Only the seven decoded functs are allowed to write back.
  function automatic logic rtype_known(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101,
      6'b100111, 6'b100110, 6'b101010: rtype_known = 1'b1;
      default:                         rtype_known = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] imm_alu(input logic [5:0] o);
    case (o)
      OP_ANDI:        imm_alu = ALU_AND;
      OP_ORI, OP_LUI: imm_alu = ALU_OR;
      default:        imm_alu = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) cur_state <= FETCH;
    else       cur_state <= nxt_state;
  end

  // Debug view of the state is masked during reset like every other output.
  assign state = reset ? 4'd0 : cur_state;

  always_comb begin
    nxt_state = FETCH;
    pcen      = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    memwrite  = 1'b0;
    iord      = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    regdst    = 1'b0;
    memtoreg  = 1'b0;
    alucont   = 4'b0000;
    signext   = 1'b0;
    shiftl16  = 1'b0;
    // The register itself returns to FETCH on the reset edge. The outputs
    // are held at 0 here so that no write or PC update occurs that cycle.
    if (!reset) begin
      case (cur_state)
        FETCH: begin
          alusrcb   = 2'b01;
          alucont   = ALU_ADD;
          irwrite   = 1'b1;
          pcen      = 1'b1;
          nxt_state = DECODE;
        end
        DECODE: begin
          // Branch target is computed early: PC+4 + (imm<<2).
          alusrcb = 2'b11;
          alucont = ALU_ADD;
          signext = 1'b1;
          case (op)
            OP_LW, OP_SW:                     nxt_state = MEMADR;
            OP_RTYPE:                         nxt_state = RTEXEC;
            OP_BEQ, OP_BNE:                   nxt_state = BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: nxt_state = IEXEC;
            OP_J:                             nxt_state = JUMP;
            default:                          nxt_state = FETCH;
          endcase
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          alucont = ALU_ADD;
          signext = 1'b1;
          if (op == OP_SW)      nxt_state = MEMWR;
          else if (op == OP_LW) nxt_state = MEMRD;
          else                  nxt_state = FETCH;
        end
        MEMRD: begin
          iord      = 1'b1;
          nxt_state = MEMWB;
        end
        MEMWB: begin
          memtoreg  = 1'b1;
          regwrite  = 1'b1;
          nxt_state = FETCH;
        end
        MEMWR: begin
          iord      = 1'b1;
          memwrite  = 1'b1;
          nxt_state = FETCH;
        end
        RTEXEC, RTWB: begin
          alusrca = 1'b1;
          alucont = rtype_alu(funct);
          if (cur_state == RTWB) begin
            regdst    = 1'b1;
            regwrite  = rtype_known(funct);
            nxt_state = FETCH;
          end else begin
            nxt_state = RTWB;
          end
        end
        BRANCH: begin
          alusrca   = 1'b1;
          alucont   = ALU_SUB;
          pcsrc     = 2'b01;
          pcen      = (op == OP_BEQ) ? zero : ((op == OP_BNE) ? ~zero : 1'b0);
          nxt_state = FETCH;
        end
        IEXEC, IWB: begin
          alusrca  = 1'b1;
          alusrcb  = 2'b10;
          alucont  = imm_alu(op);
          signext  = (op == OP_ADDI);
          shiftl16 = (op == OP_LUI);
          if (cur_state == IWB) begin
            regwrite  = 1'b1;
            nxt_state = FETCH;
          end else begin
            nxt_state = IWB;
          end
        end
        JUMP: begin
          pcsrc     = 2'b10;
          pcen      = 1'b1;
          nxt_state = FETCH;
        end
        default: nxt_state = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios followed by
// random instruction streams compared against a table-driven model.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, irwrite, regwrite, memwrite, iord, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       regdst, memtoreg;
  logic [3:0] alucont;
  logic       signext, shiftl16;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
    .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .regdst(regdst), .memtoreg(memtoreg), .alucont(alucont),
    .signext(signext), .shiftl16(shiftl16), .state(state)
  );

  always #5 clk = ~clk;

  wire [17:0] obs = {pcen, irwrite, regwrite, memwrite, iord, alusrca, alusrcb,
                     pcsrc, regdst, memtoreg, alucont, signext, shiftl16};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // R-type funct -> ALU code, as a lookup table.
  logic [5:0] rt_f [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26, 6'h2a};
  logic [3:0] rt_a [7] = '{4'h2, 4'h6, 4'h0, 4'h1, 4'h8, 4'h9, 4'h7};

  function automatic int rt_idx(input logic [5:0] f);
    for (int i = 0; i < 7; i++) if (rt_f[i] == f) return i;
    return -1;
  endfunction

  // Expected outputs for a given state of an instruction.
  function automatic logic [17:0] model(input int st, input logic [5:0] o,
                                        input logic [5:0] f, input logic z);
    logic pc_e, ir_w, rg_w, mm_w, io, sa, rd, mr, se, sh;
    logic [1:0] sb, ps;
    logic [3:0] ac;
    int ri;
    {pc_e, ir_w, rg_w, mm_w, io, sa, rd, mr, se, sh} = '0;
    sb = 0; ps = 0; ac = 0;
    ri = rt_idx(f);
    case (st)
      0:  begin sb = 1; ac = 2; ir_w = 1; pc_e = 1; end
      1:  begin sb = 3; ac = 2; se = 1; end
      2:  begin sa = 1; sb = 2; ac = 2; se = 1; end
      3:  io = 1;
      4:  begin mr = 1; rg_w = 1; end
      5:  begin io = 1; mm_w = 1; end
      6, 7: begin
        sa = 1;
        ac = (ri < 0) ? 4'd2 : rt_a[ri];
        if (st == 7) begin rd = 1; rg_w = (ri >= 0); end
      end
      8:  begin sa = 1; ac = 6; ps = 1; pc_e = (o == 6'h04) ? z : ~z; end
      9, 10: begin
        sa = 1; sb = 2;
        if (o == 6'h08) begin ac = 2; se = 1; end
        else if (o == 6'h0c) ac = 0;
        else begin ac = 1; sh = (o == 6'h0f); end
        if (st == 10) rg_w = 1;
      end
      11: begin ps = 2; pc_e = 1; end
      default: ;
    endcase
    return {pc_e, ir_w, rg_w, mm_w, io, sa, sb, ps, rd, mr, ac, se, sh};
  endfunction

  // Entered just after a rising edge with the DUT in FETCH. If cut >= 0,
  // reset is asserted during that step of the instruction.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int cut, input string nm);
    int p[$];
    case (o)
      6'h23:                     p = '{0, 1, 2, 3, 4};
      6'h2b:                     p = '{0, 1, 2, 5};
      6'h00:                     p = '{0, 1, 6, 7};
      6'h04, 6'h05:              p = '{0, 1, 8};
      6'h08, 6'h0c, 6'h0d, 6'h0f: p = '{0, 1, 9, 10};
      6'h02:                     p = '{0, 1, 11};
      default:                   p = '{0, 1};
    endcase
    op = o; funct = f; zero = z;
    foreach (p[k]) begin
      if (k == cut) begin
        reset = 1'b1;
        #1;
        chk({nm, "_rst_outs"}, {obs, state}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk({nm, "_rst_state"}, state, 0);
        return;
      end
      #1;
      chk($sformatf("%s_state%0d", nm, k), state, p[k]);
      chk($sformatf("%s_outs%0d", nm, k), obs, model(p[k], o, f, z));
      chk({nm, "_one_write"}, regwrite & memwrite, 0);
      chk({nm, "_irwrite_fetch"}, irwrite & (state != 0), 0);
      @(posedge clk); #1;
    end
    #1;
    chk({nm, "_ret_fetch"}, state, 0);
  endtask

  logic [5:0] ops [10] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h05,
                           6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h02};

  initial begin
    logic [5:0] ro, rf;
    int cut;
    reset = 1'b1; op = 0; funct = 0; zero = 0;
    @(posedge clk); #1;
    chk("reset_outs", {obs, state}, 32'd0);
    @(posedge clk); #1;
    chk("reset_outs2", {obs, state}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_state", state, 0);
    chk("post_reset_pcen", pcen, 1);
    chk("post_reset_irwrite", irwrite, 1);
    chk("post_reset_alusrcb", alusrcb, 2'b01);
    chk("post_reset_alucont", alucont, 4'b0010);

    run_instr(6'h23, 6'h00, 1'b0, -1, "lw");
    run_instr(6'h00, 6'h27, 1'b0, -1, "nor");
    run_instr(6'h00, 6'h3f, 1'b0, -1, "rt_bad");
    run_instr(6'h05, 6'h00, 1'b0, -1, "bne_z0");
    run_instr(6'h05, 6'h00, 1'b1, -1, "bne_z1");
    run_instr(6'h04, 6'h00, 1'b1, -1, "beq_z1");
    run_instr(6'h04, 6'h00, 1'b0, -1, "beq_z0");
    run_instr(6'h0f, 6'h00, 1'b0, -1, "lui");
    run_instr(6'h02, 6'h00, 1'b0, -1, "j");
    run_instr(6'h2b, 6'h00, 1'b0, 3, "sw_rst");
    run_instr(6'h2b, 6'h00, 1'b0, -1, "sw");
    run_instr(6'h3f, 6'h00, 1'b0, -1, "nop");

    for (int i = 0; i < 300; i++) begin
      ro = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : rt_f[$urandom_range(0, 6)];
      cut = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(ro, rf, 1'($urandom), cut, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
